// File: rtl/uart_alu_interface.sv
// UART byte-frame ALU: collects A, B and opcode from rx, computes in one
// registered cycle, then hands the result to tx with a start/done handshake.
module uart_alu_interface #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_op_error,
  output logic               o_overrun
);

  localparam logic [2:0] WAIT_A  = 3'd0;
  localparam logic [2:0] WAIT_B  = 3'd1;
  localparam logic [2:0] WAIT_OP = 3'd2;
  localparam logic [2:0] COMPUTE = 3'd3;
  localparam logic [2:0] SEND    = 3'd4;

  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'('h20);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'('h22);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'('h24);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'('h25);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'('h26);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'('h27);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'('h02);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'('h03);

  localparam logic [NB_DATA-1:0] SH_MAX = NB_DATA'(NB_DATA);

  logic [2:0]         r_state;
  logic [NB_DATA-1:0] r_a;
  logic [NB_DATA-1:0] r_b;
  logic [NB_OP-1:0]   r_op;
  logic [NB_DATA-1:0] r_result;
  logic               r_valid_prev;
  logic               r_tx_start;
  logic               r_overrun;

  logic               w_accept;
  logic               w_busy;
  logic [NB_DATA-1:0] w_alu;
  logic               w_unsup;

  assign w_accept = i_rx_valid & ~r_valid_prev;
  assign w_busy   = (r_state == COMPUTE) | (r_state == SEND);

  always_comb begin
    w_alu   = '0;
    w_unsup = 1'b0;
    case (r_op)
      OP_ADD: w_alu = r_a + r_b;
      OP_SUB: w_alu = r_a - r_b;
      OP_AND: w_alu = r_a & r_b;
      OP_OR:  w_alu = r_a | r_b;
      OP_XOR: w_alu = r_a ^ r_b;
      OP_NOR: w_alu = ~(r_a | r_b);
      OP_SRL: w_alu = (r_b >= SH_MAX) ? '0 : (r_a >> r_b);
      OP_SRA: begin
        if (r_b >= SH_MAX) w_alu = {NB_DATA{r_a[NB_DATA-1]}};
        else               w_alu = $signed(r_a) >>> r_b;
      end
      default: w_unsup = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state      <= WAIT_A;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_result     <= '0;
      r_valid_prev <= 1'b0;
      r_tx_start   <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_valid_prev <= i_rx_valid;
      r_tx_start   <= 1'b0;
      r_overrun    <= w_accept & w_busy;
      case (r_state)
        WAIT_A: if (w_accept) begin
          r_a     <= i_rx_data;
          r_state <= WAIT_B;
        end
        WAIT_B: if (w_accept) begin
          r_b     <= i_rx_data;
          r_state <= WAIT_OP;
        end
        WAIT_OP: if (w_accept) begin
          r_op    <= i_rx_data[NB_OP-1:0];
          r_state <= COMPUTE;
        end
        COMPUTE: begin
          r_result   <= w_alu;
          r_tx_start <= 1'b1;
          r_state    <= SEND;
        end
        SEND: if (i_tx_done) r_state <= WAIT_A;
        default: r_state <= WAIT_A;
      endcase
    end
  end

  // Error flag is live during the single COMPUTE cycle only.
  assign o_op_error = (r_state == COMPUTE) & w_unsup;
  assign o_tx_data  = r_result;
  assign o_tx_start = r_tx_start;
  assign o_overrun  = r_overrun;

endmodule
